// File: rtl/i2s_tx_ctrl_pkg.sv
// Shared definitions for the I2S transmit sequencer: word size, FSM encoding
// and the saturating underrun counter helper.
package i2s_tx_ctrl_pkg;

  localparam int I2S_WORD_BITS  = 32;
  localparam int UNDERRUN_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SLOT = 2'd1,
    ST_PRESENT   = 2'd2,
    ST_RELEASE   = 2'd3
  } state_t;

  function automatic logic [UNDERRUN_CNT_W-1:0] sat_inc(input logic [UNDERRUN_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/i2s_tx_clkgen.sv
// Bit-clock / word-select generator for the I2S master, plus the one-cycle
// strobe marking the pair-update slot inside the right half-frame.
module i2s_tx_clkgen
  import i2s_tx_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int UPD_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic sck,
  output logic ws,
  output logic upd_stb
);

  localparam int BIT_W = $clog2(I2S_WORD_BITS);
  localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(I2S_WORD_BITS - 1);
  localparam logic [BIT_W-1:0] UPD_IDX  = BIT_W'(UPD_BIT);

  logic [7:0]       div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             wrap;
  logic             fall;

  assign wrap    = (div_cnt == DIV_LAST);
  assign fall    = wrap && sck;
  assign upd_stb = enable && fall && ws && (bit_cnt == UPD_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      sck     <= 1'b0;
      ws      <= 1'b0;
    end else if (!enable) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      sck     <= 1'b0;
      ws      <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      sck     <= ~sck;
      // Bit position (and word select) advance on the falling toggle only
      if (sck) begin
        bit_cnt <= bit_cnt + 1'b1;
        if (bit_cnt == BIT_LAST) ws <= ~ws;
      end
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_tx_ctrl.sv
// I2S master transmit sequencer: stereo-pair buffer, slot-aligned handshake
// FSM towards the TX core, and underrun accounting.
module i2s_tx_ctrl
  import i2s_tx_ctrl_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int DEPTH_LOG2 = 3,
  parameter int UPD_BIT    = 16
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      enable_i,
  input  logic                      push_i,
  input  logic [I2S_WORD_BITS-1:0]  push_left_i,
  input  logic [I2S_WORD_BITS-1:0]  push_right_i,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [DEPTH_LOG2:0]       level_o,
  output logic [I2S_WORD_BITS-1:0]  fifo_left_data,
  output logic [I2S_WORD_BITS-1:0]  fifo_right_data,
  output logic                      fifo_ready,
  input  logic                      fifo_ack,
  output logic                      i2s_enable_o,
  output logic                      i2s_sck_o,
  output logic                      i2s_ws_o,
  output logic                      underrun_o,
  input  logic                      underrun_clr_i,
  output logic [UNDERRUN_CNT_W-1:0] underrun_cnt_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [I2S_WORD_BITS-1:0] mem_left  [DEPTH];
  logic [I2S_WORD_BITS-1:0] mem_right [DEPTH];
  logic [DEPTH_LOG2-1:0]    wr_ptr;
  logic [DEPTH_LOG2-1:0]    rd_ptr;
  logic [DEPTH_LOG2:0]      level;
  logic                     ack_m;
  logic                     ack_s;
  logic                     upd_stb;
  logic                     in_slot;
  logic                     pop;
  logic                     push_ok;
  logic                     underrun_evt;
  state_t                   state;

  i2s_tx_clkgen #(
    .CLK_DIV (CLK_DIV),
    .UPD_BIT (UPD_BIT)
  ) u_clkgen (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .enable  (enable_i),
    .sck     (i2s_sck_o),
    .ws      (i2s_ws_o),
    .upd_stb (upd_stb)
  );

  assign level_o = level;
  assign full_o  = (level == LVL_FULL);
  assign empty_o = (level == '0);

  // A pop frees the slot being written, so a push at full is still taken
  // when it coincides with a pop; level 0 never bypasses.
  always_comb begin
    in_slot      = enable_i && upd_stb && (state == ST_WAIT_SLOT);
    pop          = in_slot && !empty_o && !ack_s;
    underrun_evt = in_slot && !pop;
    push_ok      = push_i && (!full_o || pop);
  end

  always_ff @(posedge wb_clk_i) begin
    if (push_ok) begin
      mem_left[wr_ptr]  <= push_left_i;
      mem_right[wr_ptr] <= push_right_i;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_m        <= 1'b0;
      ack_s        <= 1'b0;
      i2s_enable_o <= 1'b0;
    end else begin
      ack_m        <= fifo_ack;
      ack_s        <= ack_m;
      i2s_enable_o <= enable_i;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state           <= ST_IDLE;
      fifo_ready      <= 1'b0;
      fifo_left_data  <= '0;
      fifo_right_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          fifo_ready <= 1'b0;
          if (enable_i) state <= ST_WAIT_SLOT;
        end
        ST_WAIT_SLOT: begin
          if (pop) begin
            fifo_left_data  <= mem_left[rd_ptr];
            fifo_right_data <= mem_right[rd_ptr];
            fifo_ready      <= 1'b1;
            state           <= ST_PRESENT;
          end else if (in_slot) begin
            fifo_left_data  <= '0;
            fifo_right_data <= '0;
            fifo_ready      <= 1'b0;
          end
        end
        ST_PRESENT: begin
          if (ack_s) begin
            fifo_ready <= 1'b0;
            state      <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!ack_s) state <= ST_WAIT_SLOT;
        end
        default: state <= ST_IDLE;
      endcase
      // Disable overrides every state; data regs deliberately keep their value
      if (!enable_i) begin
        state      <= ST_IDLE;
        fifo_ready <= 1'b0;
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      underrun_o     <= 1'b0;
      underrun_cnt_o <= '0;
    end else if (underrun_clr_i) begin
      underrun_o     <= 1'b0;
      underrun_cnt_o <= '0;
    end else if (underrun_evt) begin
      underrun_o     <= 1'b1;
      underrun_cnt_o <= sat_inc(underrun_cnt_o);
    end
  end

endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// Directed bench for i2s_tx_ctrl: scoreboard of pushed pairs checked against
// each presentation, plus clock, underrun, full and enable scenarios.
module tb_i2s_tx_ctrl;
  import i2s_tx_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable_i = 1'b0;
  logic        push_i = 1'b0;
  logic [31:0] push_left_i = '0;
  logic [31:0] push_right_i = '0;
  logic        full_o, empty_o;
  logic [3:0]  level_o;
  logic [31:0] fifo_left_data, fifo_right_data;
  logic        fifo_ready;
  logic        fifo_ack;
  logic        i2s_enable_o, i2s_sck_o, i2s_ws_o;
  logic        underrun_o;
  logic        underrun_clr_i = 1'b0;
  logic [15:0] underrun_cnt_o;

  logic        core_auto = 1'b1;
  logic        model_ack = 1'b0;
  logic        hold_ack = 1'b0;
  logic        prev_ready = 1'b0;
  logic [63:0] sb_q[$];
  logic [63:0] exp_pair;
  int          checks = 0;
  int          errors = 0;
  int          n_presented = 0;

  assign fifo_ack = model_ack | hold_ack;

  i2s_tx_ctrl #(.CLK_DIV(4), .DEPTH_LOG2(3), .UPD_BIT(16)) dut (
    .wb_clk_i        (clk),
    .wb_rst_i        (rst),
    .enable_i        (enable_i),
    .push_i          (push_i),
    .push_left_i     (push_left_i),
    .push_right_i    (push_right_i),
    .full_o          (full_o),
    .empty_o         (empty_o),
    .level_o         (level_o),
    .fifo_left_data  (fifo_left_data),
    .fifo_right_data (fifo_right_data),
    .fifo_ready      (fifo_ready),
    .fifo_ack        (fifo_ack),
    .i2s_enable_o    (i2s_enable_o),
    .i2s_sck_o       (i2s_sck_o),
    .i2s_ws_o        (i2s_ws_o),
    .underrun_o      (underrun_o),
    .underrun_clr_i  (underrun_clr_i),
    .underrun_cnt_o  (underrun_cnt_o)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // TX core model: ack while a pair is offered, drop once it is withdrawn
  always @(negedge clk) model_ack = core_auto && fifo_ready;

  // Scoreboard: every rising fifo_ready must present the oldest pending pair
  always @(negedge clk) begin
    if (rst) begin
      prev_ready = 1'b0;
    end else begin
      if (fifo_ready && !prev_ready) begin
        check("sb_pending", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          exp_pair = sb_q.pop_front();
          check("pair", {fifo_left_data, fifo_right_data}, exp_pair);
        end
        n_presented++;
      end
      prev_ready = fifo_ready;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push_pair(input logic [31:0] l, input logic [31:0] r, input bit accept);
    push_i = 1'b1;
    push_left_i = l;
    push_right_i = r;
    if (accept) sb_q.push_back({l, r});
    step();
    push_i = 1'b0;
  endtask

  // Returns at a falling edge where the update-slot strobe is active
  task automatic wait_slot(input string tag);
    int n = 0;
    step();
    while (!dut.upd_stb && n < 1200) begin
      step();
      n++;
    end
    check(tag, 64'(n >= 1200), 64'd0);
  endtask

  task automatic wait_presented(input int target, input string tag);
    int n = 0;
    while (n_presented < target && n < 6000) begin
      step();
      n++;
    end
    check(tag, 64'(n >= 6000), 64'd0);
  endtask

  initial begin
    int  n;
    bit  prev;

    // Reset state
    step();
    check("rst_outs", {full_o, fifo_ready, i2s_enable_o, i2s_sck_o, i2s_ws_o, underrun_o}, 64'd0);
    check("rst_empty", {empty_o, level_o}, {1'b1, 4'd0});
    check("rst_data", {fifo_left_data, fifo_right_data}, 64'd0);
    check("rst_ucnt", underrun_cnt_o, 64'd0);
    rst = 1'b0;
    enable_i = 1'b1;

    // sck period
    n = 0;
    prev = i2s_sck_o;
    while (n < 100) begin
      step(); n++;
      if (i2s_sck_o && !prev) break;
      prev = i2s_sck_o;
    end
    n = 0;
    prev = i2s_sck_o;
    while (n < 100) begin
      step(); n++;
      if (i2s_sck_o && !prev) break;
      prev = i2s_sck_o;
    end
    check("sck_period", n, 8);

    // ws half-frame length
    n = 0;
    prev = i2s_ws_o;
    while (n < 600) begin
      step(); n++;
      if (i2s_ws_o != prev) break;
    end
    n = 0;
    prev = i2s_ws_o;
    while (n < 600) begin
      step(); n++;
      if (i2s_ws_o != prev) break;
    end
    check("ws_half", n, 256);

    n = 0;
    for (int i = 0; i < 512; i++) begin
      step();
      if (dut.upd_stb) n++;
    end
    check("slots_per_frame", n, 1);

    // Asynchronous reset mid-frame
    rst = 1'b1;
    #1;
    check("amid_outs", {full_o, fifo_ready, i2s_enable_o, i2s_sck_o, i2s_ws_o, underrun_o}, 64'd0);
    check("amid_empty", {empty_o, level_o, underrun_cnt_o}, {1'b1, 4'd0, 16'd0});
    step();
    rst = 1'b0;
    n = 0;
    while (!i2s_sck_o && n < 20) begin
      step(); n++;
    end
    check("sck_restart", n, 4);

    // Three pairs presented in order
    for (int i = 1; i <= 3; i++)
      push_pair(32'hA000_0000 | 32'(i), 32'hB000_0000 | 32'(i), 1'b1);
    check("lvl3", level_o, 3);
    wait_presented(3, "pres3_to");
    check("lvl0", {empty_o, level_o}, {1'b1, 4'd0});
    check("no_underrun", {underrun_o, underrun_cnt_o}, 64'd0);

    // Underrun at empty slot, then clear racing a second underrun
    wait_slot("slot_ur_to");
    step();
    check("ur_silence", {fifo_ready, fifo_left_data, fifo_right_data}, 65'd0);
    check("ur_flag", {underrun_o, underrun_cnt_o}, {1'b1, 16'd1});
    wait_slot("slot_clr_to");
    underrun_clr_i = 1'b1;
    step();
    underrun_clr_i = 1'b0;
    check("ur_clr_wins", {underrun_o, underrun_cnt_o}, 64'd0);

    // Fill to full, overflow push dropped, then push+pop at full
    for (int i = 1; i <= 8; i++)
      push_pair(32'hC000_0000 | 32'(i), 32'hD000_0000 | 32'(i), 1'b1);
    check("full8", {full_o, level_o}, {1'b1, 4'd8});
    push_pair(32'hE000_0009, 32'hE100_0009, 1'b0);
    check("full_drop", {full_o, level_o}, {1'b1, 4'd8});
    wait_slot("slot_full_to");
    push_pair(32'hF000_000A, 32'hF100_000A, 1'b1);
    check("pushpop_full", level_o, 8);
    wait_presented(12, "drain_to");
    check("drained", 64'(sb_q.size()), 64'd0);
    check("drained_lvl", level_o, 0);

    // Slot arriving while ack is held is ignored
    underrun_clr_i = 1'b1;
    step();
    underrun_clr_i = 1'b0;
    push_pair(32'h1111_0001, 32'h2222_0001, 1'b1);
    push_pair(32'h1111_0002, 32'h2222_0002, 1'b1);
    wait_presented(13, "pres_g_to");
    hold_ack = 1'b1;
    wait_slot("slot_hold_to");
    step();
    check("hold_nopop", level_o, 1);
    check("hold_nour", {underrun_o, underrun_cnt_o}, 64'd0);
    check("hold_data", fifo_left_data, 32'h1111_0001);
    check("hold_state", 64'(dut.state), 64'(ST_RELEASE));

    // Disable during PRESENT, then re-enable
    core_auto = 1'b0;
    hold_ack = 1'b0;
    wait_presented(14, "pres_h_to");
    check("present_state", 64'(dut.state), 64'(ST_PRESENT));
    enable_i = 1'b0;
    step();
    check("dis_ready", {fifo_ready, i2s_enable_o, i2s_sck_o, i2s_ws_o}, 64'd0);
    check("dis_state", 64'(dut.state), 64'(ST_IDLE));
    check("dis_data", {fifo_left_data, fifo_right_data}, {32'h1111_0002, 32'h2222_0002});
    enable_i = 1'b1;
    step();
    check("reen_state", 64'(dut.state), 64'(ST_WAIT_SLOT));
    check("reen_en", i2s_enable_o, 1);
    core_auto = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
